collatz_engine: RTL and testbench

Parametrised successor to the fixed 16-bit Collatz iterator sitting behind the user_project_wrapper.
- Takes a seed on a start handshake and iterates n -> n/2 (even) or n -> 3n+1 (odd) until n == 1.
- Reports step count, peak value and error status, with a done pulse on completion.
- Adds selectable width, a step-counter width, a shortcut mode ((3n+1)/2 in one cycle), overflow/saturation detection and abort.

---
 rtl/collatz_engine.sv | 148 ++++++++++++++
 tb/tb_collatz_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_engine.sv
// Collatz iterator: accepts a seed on a start handshake and iterates
// n -> n/2 (even) or n -> 3n+1 (odd) until n == 1, reporting the step
// count, the peak value and an error status with a one-cycle done pulse.
// Shortcut mode folds the odd step and the halving that always follows it
// into a single cycle, counting it as two standard steps.
//
// Handshake: a request is taken on any rising edge where start && ready;
// seed and mode are sampled on that same edge. ready is high whenever the
// engine is not busy (IDLE or DONE), so a new start may be issued while the
// previous result is still being held.
module collatz_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x,
    output logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] peak,
    output logic             err_zero,
    output logic             err_ovf,
    output logic             err_sat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    logic   mode_q;

    // Datapath for one iteration, evaluated on the current x.
    // 3x+1 is formed two bits wider so an overflow is visible rather than lost.
    logic [WIDTH+1:0] x_wide;
    logic [WIDTH+1:0] x3p1;
    logic             x_odd;
    logic             x_is_one;
    logic             ovf;
    logic [1:0]       inc;
    logic [CNT_W:0]   steps_sum;
    logic             sat;
    logic [WIDTH-1:0] x_next;

    // Next-value, overflow and saturation detection for the current x.
    always_comb begin
        x_wide    = {2'b00, x};
        x3p1      = (x_wide << 1) + x_wide + {{(WIDTH+1){1'b0}}, 1'b1};
        x_odd     = x[0];
        x_is_one  = (x == {{(WIDTH-1){1'b0}}, 1'b1});
        ovf       = x_odd && (x3p1[WIDTH+1:WIDTH] != 2'b00);
        inc       = (x_odd && mode_q) ? 2'd2 : 2'd1;
        steps_sum = {1'b0, steps} + {{(CNT_W-1){1'b0}}, inc};
        sat       = steps_sum[CNT_W];
        x_next    = x >> 1;
        if (x_odd) begin
            if (mode_q) begin
                x_next = x3p1[WIDTH:1];
            end else begin
                x_next = x3p1[WIDTH-1:0];
            end
        end
    end

    assign ready = ~busy;

    // Control FSM plus all result registers; outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            x        <= '0;
            steps    <= '0;
            peak     <= '0;
            err_zero <= 1'b0;
            err_ovf  <= 1'b0;
            err_sat  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // abort is meaningless here; start alone decides
                    if (start) begin
                        x        <= seed;
                        peak     <= seed;
                        steps    <= '0;
                        mode_q   <= mode;
                        err_ovf  <= 1'b0;
                        err_sat  <= 1'b0;
                        if (seed == '0) begin
                            state    <= S_DONE;
                            err_zero <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state    <= S_RUN;
                            err_zero <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // partial x/steps/peak are left visible
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (x_is_one) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (ovf) begin
                        // checked before saturation so only one flag can rise
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err_ovf <= 1'b1;
                    end else if (sat) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err_sat <= 1'b1;
                    end else begin
                        x     <= x_next;
                        steps <= steps_sum[CNT_W-1:0];
                        if (x_next > peak) begin
                            peak <= x_next;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: three instances (16/16, WIDTH=8, CNT_W=4) share
// one clock. The driver pushes hand-computed results into per-instance
// queues; the monitor pops and compares whenever an instance pulses done.
module tb_collatz_engine;

  logic clk;
  logic rst;

  logic        start_s [3];
  logic [15:0] seed_s  [3];
  logic        mode_s  [3];
  logic        abort_s [3];

  logic        ready_o [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic [15:0] x_o     [3];
  logic [15:0] steps_o [3];
  logic [15:0] peak_o  [3];
  logic [2:0]  err_o   [3];

  // raw instance outputs
  logic        ready_a, busy_a, done_a, ez_a, eo_a, es_a;
  logic [15:0] x_a, steps_a, peak_a;
  logic        ready_b, busy_b, done_b, ez_b, eo_b, es_b;
  logic [7:0]  x_b, peak_b;
  logic [15:0] steps_b;
  logic        ready_c, busy_c, done_c, ez_c, eo_c, es_c;
  logic [15:0] x_c, peak_c;
  logic [3:0]  steps_c;

  // {lat[15:0], x, steps, peak, err_zero/ovf/sat, busy, ready}
  logic [68:0] exp_q [3][$];

  int cyc;
  int acc_cyc [3];
  int n_cmp;
  int n_fail;

  collatz_engine u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .seed(seed_s[0]), .mode(mode_s[0]),
    .abort(abort_s[0]), .ready(ready_a), .busy(busy_a), .done(done_a), .x(x_a),
    .steps(steps_a), .peak(peak_a), .err_zero(ez_a), .err_ovf(eo_a), .err_sat(es_a)
  );

  collatz_engine #(.WIDTH(8), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .seed(seed_s[1][7:0]), .mode(mode_s[1]),
    .abort(abort_s[1]), .ready(ready_b), .busy(busy_b), .done(done_b), .x(x_b),
    .steps(steps_b), .peak(peak_b), .err_zero(ez_b), .err_ovf(eo_b), .err_sat(es_b)
  );

  collatz_engine #(.WIDTH(16), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .seed(seed_s[2]), .mode(mode_s[2]),
    .abort(abort_s[2]), .ready(ready_c), .busy(busy_c), .done(done_c), .x(x_c),
    .steps(steps_c), .peak(peak_c), .err_zero(ez_c), .err_ovf(eo_c), .err_sat(es_c)
  );

  always_comb begin
    ready_o[0] = ready_a; busy_o[0] = busy_a; done_o[0] = done_a;
    x_o[0] = x_a; steps_o[0] = steps_a; peak_o[0] = peak_a; err_o[0] = {ez_a, eo_a, es_a};
    ready_o[1] = ready_b; busy_o[1] = busy_b; done_o[1] = done_b;
    x_o[1] = {8'h00, x_b}; steps_o[1] = steps_b; peak_o[1] = {8'h00, peak_b};
    err_o[1] = {ez_b, eo_b, es_b};
    ready_o[2] = ready_c; busy_o[2] = busy_c; done_o[2] = done_c;
    x_o[2] = x_c; steps_o[2] = {12'h000, steps_c}; peak_o[2] = peak_c;
    err_o[2] = {ez_c, eo_c, es_c};
  end

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_o[i]) begin
        logic [68:0] act;
        logic [68:0] exp_v;
        logic [15:0] lat;
        lat = 16'(cyc - acc_cyc[i]);
        act = {lat, x_o[i], steps_o[i], peak_o[i], err_o[i], busy_o[i], ready_o[i]};
        n_cmp++;
        if (exp_q[i].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done inst%0d: got done with lat=%0d x=%0d steps=%0d, required no done",
                   i, lat, x_o[i], steps_o[i]);
        end else begin
          exp_v = exp_q[i].pop_front();
          if (act !== exp_v) begin
            n_fail++;
            $display("FAIL result inst%0d: got lat=%0d x=%0d steps=%0d peak=%0d err=%b busy/ready=%b, required lat=%0d x=%0d steps=%0d peak=%0d err=%b busy/ready=%b",
                     i, act[68:53], act[52:37], act[36:21], act[20:5], act[4:2], act[1:0],
                     exp_v[68:53], exp_v[52:37], exp_v[36:21], exp_v[20:5], exp_v[4:2], exp_v[1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
    end
  endtask

  // waits (bounded) until instance i is ready, ending just after a negedge
  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_o[i] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!ready_o[i]) begin
      n_fail++;
      $display("FAIL ready_timeout inst%0d: got ready=0 after %0d cycles, required ready=1", i, n);
    end
    #1;
  endtask

  // driver: issue one request; push its expected result when push=1
  task automatic issue(input int i, input logic [15:0] sd, input logic md, input bit push,
                       input int lat, input logic [15:0] ex, input logic [15:0] es,
                       input logic [15:0] ep, input logic [2:0] ee);
    wait_ready(i);
    start_s[i] = 1'b1;
    seed_s[i]  = sd;
    mode_s[i]  = md;
    acc_cyc[i] = cyc;
    if (push) exp_q[i].push_back({16'(lat), ex, es, ep, ee, 2'b01});
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; seed_s[i] = '0; mode_s[i] = 1'b0; abort_s[i] = 1'b0; acc_cyc[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state_inst%0d", i),
            64'({x_o[i], steps_o[i], peak_o[i], err_o[i], done_o[i], busy_o[i], ready_o[i]}),
            64'({48'h0, 3'b000, 3'b001}));
    end
    rst = 1'b0;

    // standard, shortcut, long run, seed 1, seed 0 on the 16/16 instance
    issue(0, 16'd6, 1'b0, 1'b1, 10, 16'd1, 16'd8, 16'd16, 3'b000);
    issue(0, 16'd6, 1'b1, 1'b1, 8, 16'd1, 16'd8, 16'd8, 3'b000);
    // overflow cases on the 8-bit instance run alongside
    issue(1, 16'd27, 1'b0, 1'b1, 13, 16'd107, 16'd11, 16'd214, 3'b010);
    issue(0, 16'd27, 1'b0, 1'b1, 113, 16'd1, 16'd111, 16'd9232, 3'b000);
    // a start while busy must be ignored
    repeat (5) @(negedge clk);
    #1;
    start_s[0] = 1'b1; seed_s[0] = 16'd5;
    @(negedge clk);
    #1;
    start_s[0] = 1'b0;
    issue(1, 16'd27, 1'b1, 1'b1, 8, 16'd107, 16'd11, 16'd107, 3'b010);
    // saturation on the 4-bit counter instance
    issue(2, 16'd27, 1'b0, 1'b1, 17, 16'd242, 16'd15, 16'd484, 3'b001);
    issue(0, 16'd1, 1'b0, 1'b1, 2, 16'd1, 16'd0, 16'd1, 3'b000);
    issue(0, 16'd0, 1'b0, 1'b1, 1, 16'd0, 16'd0, 16'd0, 3'b100);

    // abort after nine iterations of seed 27: 27 -> ... -> 71
    issue(0, 16'd27, 1'b0, 1'b0, 0, '0, '0, '0, '0);
    repeat (10) @(negedge clk);
    #1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    #1;
    abort_s[0] = 1'b0;
    check("abort_state",
          64'({x_o[0], steps_o[0], peak_o[0], err_o[0], busy_o[0], ready_o[0]}),
          64'({16'd71, 16'd9, 16'd142, 3'b000, 1'b0, 1'b1}));
    repeat (4) @(negedge clk);
    issue(0, 16'd6, 1'b0, 1'b1, 10, 16'd1, 16'd8, 16'd16, 3'b000);

    // start and abort together while in DONE: start wins
    wait_drain();
    abort_s[0] = 1'b1;
    issue(0, 16'd1, 1'b0, 1'b1, 2, 16'd1, 16'd0, 16'd1, 3'b000);
    abort_s[0] = 1'b0;

    // asynchronous reset in the middle of a run
    wait_drain();
    issue(0, 16'd27, 1'b0, 1'b0, 0, '0, '0, '0, '0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset",
          64'({x_o[0], steps_o[0], peak_o[0], err_o[0], done_o[0], busy_o[0], ready_o[0]}),
          64'({48'h0, 3'b000, 3'b001}));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("pending_results_inst%0d", i), 64'(exp_q[i].size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
